// File: rtl/axi_defs.sv
// Shared AXI3 encodings and FSM state types for the RAM responder.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package axi_defs;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // Only full 32-bit beats are supported by the word-wide RAM.
    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_FETCH = 2'b01,
        R_DATA  = 2'b10
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    // Burst attributes this responder cannot honour. The address range check
    // depends on the RAM depth and is done by the caller.
    function automatic logic attr_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_4B) || (burst == BURST_RSVD);
    endfunction

endpackage

// File: rtl/sram_dp.sv
// Dual-port word SRAM: one synchronous read port, one byte-enabled write port.
// Latency: read data registered one cycle after rd_en_i; writes land at the clock edge.
// Backpressure: none; read data holds its value until the next rd_en_i.
//
// Ports:
//   clk_i                           clock
//   rd_en_i, rd_addr_i, rd_data_o   read port; output is old data when a write hits the same word
//   wr_en_i, wr_addr_i, wr_be_i,
//   wr_data_i                       write port, wr_be_i[b] enables byte lane b
module sram_dp #(
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [3:0]        wr_be_i,
    input  logic [31:0]       wr_data_i
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem_q [0:DEPTH-1];
    logic [31:0] rd_data_q;

    // Contents are deliberately not reset. The read sees the pre-write value
    // because both updates are non-blocking in the same edge.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 single-ID responder serving bursts from an on-chip dual-port SRAM.
// Latency: R beat 2 cycles after AR (then one beat per 2 cycles); B one cycle after the last W beat.
// Backpressure: R outputs held stable while rready=0; B held until bready; one transaction per channel.
//
// Ports:
//   clk, rst                               clock, asynchronous active-high reset
//   ar*/r*                                 read address and read data channels
//   aw*/w*/b*                              write address, write data and write response channels
module axi_ram_slave
    import axi_defs::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,

    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,

    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,

    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,

    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    // Word index advance. FIXED (and the reserved encoding, which is already
    // flagged as an error) hold; INCR and WRAP wrap modulo the RAM depth.
    function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx,
                                                   input logic [1:0]        burst);
        return ((burst == BURST_INCR) || (burst == BURST_WRAP)) ? idx + 1'b1 : idx;
    endfunction

    // Byte offset within a word is irrelevant for 4-byte beats.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{araddr[1:0], awaddr[1:0]};

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e         r_state_q, r_state_d;
    logic [3:0]        r_id_q,    r_id_d;
    logic [ADDR_W-1:0] r_idx_q,   r_idx_d;
    logic [3:0]        r_len_q,   r_len_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic              r_err_q,   r_err_d;
    logic [3:0]        r_cnt_q,   r_cnt_d;

    logic              ram_rd_en;
    logic [31:0]       ram_rd_data;

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        r_cnt_d   = r_cnt_q;
        ram_rd_en = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_id_d    = arid;
                    r_idx_d   = araddr[ADDR_W+1:2];
                    r_len_d   = arlen;
                    r_burst_d = arburst;
                    r_err_d   = attr_err(arsize, arburst) || (araddr[31:ADDR_W+2] != '0);
                    r_cnt_d   = 4'd0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_rd_en = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (rready) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = next_idx(r_idx_q, r_burst_q);
                        r_cnt_d   = r_cnt_q + 4'd1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Beat outputs derive only from registers and the RAM read register,
    // which changes only on a fetch, so they are stable during a stall.
    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = r_id_q;
    assign rlast   = rvalid && (r_cnt_q == r_len_q);
    assign rdata   = (rvalid && !r_err_q) ? ram_rd_data : 32'd0;
    assign rresp   = (rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_e         w_state_q, w_state_d;
    logic [3:0]        w_id_q,    w_id_d;
    logic [ADDR_W-1:0] w_idx_q,   w_idx_d;
    logic [3:0]        w_len_q,   w_len_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic              w_err_q,   w_err_d;
    logic              w_perr_q,  w_perr_d;
    logic [3:0]        w_cnt_q,   w_cnt_d;

    logic              ram_wr_en;
    logic              w_final;

    assign w_final = (w_cnt_q == w_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        w_perr_d  = w_perr_q;
        w_cnt_d   = w_cnt_q;
        ram_wr_en = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    w_id_d    = awid;
                    w_idx_d   = awaddr[ADDR_W+1:2];
                    w_len_d   = awlen;
                    w_burst_d = awburst;
                    w_err_d   = attr_err(awsize, awburst) || (awaddr[31:ADDR_W+2] != '0);
                    w_perr_d  = 1'b0;
                    w_cnt_d   = 4'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    // Protocol slips are reported but the data is still stored;
                    // only address/attribute errors suppress the write.
                    ram_wr_en = !w_err_q;
                    if ((wid != w_id_q) || (wlast != w_final)) begin
                        w_perr_d = 1'b1;
                    end
                    // Termination follows the beat count, never wlast.
                    w_idx_d = next_idx(w_idx_q, w_burst_q);
                    if (w_final) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            w_perr_q  <= 1'b0;
            w_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_perr_q  <= w_perr_d;
            w_cnt_q   <= w_cnt_d;
        end
    end

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = w_id_q;
    assign bresp   = (bvalid && (w_err_q || w_perr_q)) ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sram_dp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i     (clk),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (r_idx_q),
        .rd_data_o (ram_rd_data),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (w_idx_q),
        .wr_be_i   (wstrb),
        .wr_data_i (wdata)
    );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave.
// Latency: drives and samples on the falling edge; DUT acts on the rising edge.
// Backpressure: exercised on R (rready pattern 1,0,0,1) and by holding bready low until bvalid.
module tb_axi_ram_slave;

    logic        clk;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_ram_slave #(.ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] wr_buf [16];
    logic [31:0] rd_dat [16];
    logic [1:0]  rd_resp[16];
    logic        rd_last[16];
    logic [3:0]  rd_id  [16];
    int          rd_n;
    int          rd_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                             input int early, input int abort_at,
                             output int stalls, output int bwait,
                             output logic [1:0] resp, output logic [3:0] rbid);
        int g;
        stalls = 0;
        bwait  = 0;
        resp   = 2'b00;
        rbid   = 4'h0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        g = 0;
        while (!awready && g < 50) begin @(negedge clk); g++; end
        chk("aw_ready", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_at) begin
                rst = 1'b1;
                wvalid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            wid = id;
            wdata = wr_buf[b];
            wstrb = strb;
            wlast = (early >= 0) ? (b == early) : (b == int'(len));
            wvalid = 1'b1;
            g = 0;
            while (!wready && g < 50) begin @(negedge clk); g++; stalls++; end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        g = 0;
        while (!bvalid && g < 50) begin @(negedge clk); g++; bwait++; end
        resp = bresp;
        rbid = bid;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit bp);
        int g;
        int pat;
        int beats;
        logic rr;
        logic stalled;
        logic [31:0] pd;
        logic pl;
        logic [3:0] pid;
        rd_n = 0;
        rd_lat = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        g = 0;
        while (!arready && g < 50) begin @(negedge clk); g++; end
        chk("ar_ready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        beats = 0; pat = 0; g = 0; stalled = 1'b0;
        pd = '0; pl = 1'b0; pid = '0;
        while (beats <= int'(len) && g < 400) begin
            if (rvalid) begin
                rr = bp ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'b1;
                pat++;
                if (stalled) begin
                    chk("r_hold_dat", rdata, pd);
                    chk("r_hold_last", 32'(rlast), 32'(pl));
                    chk("r_hold_id", 32'(rid), 32'(pid));
                end
                rready = rr;
                if (rr) begin
                    rd_dat[beats]  = rdata;
                    rd_resp[beats] = rresp;
                    rd_last[beats] = rlast;
                    rd_id[beats]   = rid;
                    beats++;
                    stalled = 1'b0;
                end else begin
                    pd = rdata; pl = rlast; pid = rid;
                    stalled = 1'b1;
                end
            end else begin
                rready = 1'b0;
                if (beats == 0) rd_lat++;
            end
            @(negedge clk);
            g++;
        end
        rready = 1'b0;
        rd_n = beats;
    endtask

    // Compare a completed read against wr_buf-style expectations held in exp_buf.
    logic [31:0] exp_buf [16];
    task automatic chk_read(input string tag, input int nbeats, input logic [1:0] eresp,
                            input logic [3:0] eid);
        chk({tag, "_nbeats"}, 32'(rd_n), 32'(nbeats));
        for (int i = 0; i < nbeats && i < rd_n; i++) begin
            chk($sformatf("%s_dat%0d", tag, i), rd_dat[i], exp_buf[i]);
            chk($sformatf("%s_last%0d", tag, i), 32'(rd_last[i]), 32'(i == nbeats - 1));
            chk($sformatf("%s_resp%0d", tag, i), 32'(rd_resp[i]), 32'(eresp));
            chk($sformatf("%s_id%0d", tag, i), 32'(rd_id[i]), 32'(eid));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int stalls, bwait;
    logic [1:0] wresp;
    logic [3:0] wbid;

    initial begin
        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_rchan", {rid, rresp, rlast, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bchan", {bid, bresp, bvalid}, 32'd0);

        // INCR write 0x100, 4 beats, then read back
        wr_buf[0] = 32'h11; wr_buf[1] = 32'h22; wr_buf[2] = 32'h33; wr_buf[3] = 32'h44;
        axi_write(4'h5, 32'h100, 4'd3, 2'b01, 3'b010, 4'hF, -1, -1, stalls, bwait, wresp, wbid);
        chk("incr_w_stalls", 32'(stalls), 32'd0);
        chk("incr_b_wait", 32'(bwait), 32'd0);
        chk("incr_bresp", 32'(wresp), 32'd0);
        chk("incr_bid", 32'(wbid), 32'h5);
        axi_read(4'h3, 32'h100, 4'd3, 2'b01, 3'b010, 1'b0);
        chk("incr_r_lat", 32'(rd_lat), 32'd1);
        exp_buf[0] = 32'h11; exp_buf[1] = 32'h22; exp_buf[2] = 32'h33; exp_buf[3] = 32'h44;
        chk_read("incr_r", 4, 2'b00, 4'h3);
        chk("incr_arready_after", 32'(arready), 32'd1);

        // Byte strobes
        wr_buf[0] = 32'h0;
        axi_write(4'h1, 32'h200, 4'd0, 2'b01, 3'b010, 4'hF, -1, -1, stalls, bwait, wresp, wbid);
        wr_buf[0] = 32'hAABBCCDD;
        axi_write(4'h1, 32'h200, 4'd0, 2'b01, 3'b010, 4'b0101, -1, -1, stalls, bwait, wresp, wbid);
        axi_read(4'h1, 32'h200, 4'd0, 2'b01, 3'b010, 1'b0);
        exp_buf[0] = 32'h00BB00DD;
        chk_read("strb", 1, 2'b00, 4'h1);

        // 16-beat read with rready backpressure
        for (int i = 0; i < 16; i++) wr_buf[i] = 32'hA000_0000 + 32'(i);
        axi_write(4'h2, 32'h400, 4'd15, 2'b01, 3'b010, 4'hF, -1, -1, stalls, bwait, wresp, wbid);
        chk("bp_w_bresp", 32'(wresp), 32'd0);
        axi_read(4'h7, 32'h400, 4'd15, 2'b01, 3'b010, 1'b1);
        for (int i = 0; i < 16; i++) exp_buf[i] = 32'hA000_0000 + 32'(i);
        chk_read("bp_r", 16, 2'b00, 4'h7);

        // Read errors: out-of-range address, bad size
        axi_read(4'h4, 32'h0010_0000, 4'd1, 2'b01, 3'b010, 1'b0);
        exp_buf[0] = 32'h0; exp_buf[1] = 32'h0;
        chk_read("rerr_addr", 2, 2'b10, 4'h4);
        axi_read(4'h4, 32'h100, 4'd0, 2'b01, 3'b000, 1'b0);
        chk_read("rerr_size", 1, 2'b10, 4'h4);

        // Write with bad size: SLVERR and RAM untouched
        wr_buf[0] = 32'hDEAD_BEEF;
        axi_write(4'h6, 32'h100, 4'd0, 2'b01, 3'b000, 4'hF, -1, -1, stalls, bwait, wresp, wbid);
        chk("werr_size_bresp", 32'(wresp), 32'h2);
        axi_read(4'h6, 32'h100, 4'd0, 2'b01, 3'b010, 1'b0);
        exp_buf[0] = 32'h11;
        chk_read("werr_size_r", 1, 2'b00, 4'h6);

        // Early wlast: all beats consumed and written, SLVERR response
        for (int i = 0; i < 4; i++) wr_buf[i] = 32'hC0 + 32'(i);
        axi_write(4'h8, 32'h300, 4'd3, 2'b01, 3'b010, 4'hF, 1, -1, stalls, bwait, wresp, wbid);
        chk("wlast_stalls", 32'(stalls), 32'd0);
        chk("wlast_bresp", 32'(wresp), 32'h2);
        axi_read(4'h8, 32'h300, 4'd3, 2'b01, 3'b010, 1'b0);
        for (int i = 0; i < 4; i++) exp_buf[i] = 32'hC0 + 32'(i);
        chk_read("wlast_r", 4, 2'b00, 4'h8);

        // FIXED burst
        wr_buf[0] = 32'd1; wr_buf[1] = 32'd2; wr_buf[2] = 32'd3;
        axi_write(4'hA, 32'h500, 4'd2, 2'b00, 3'b010, 4'hF, -1, -1, stalls, bwait, wresp, wbid);
        chk("fixed_bresp", 32'(wresp), 32'd0);
        axi_read(4'hA, 32'h500, 4'd1, 2'b00, 3'b010, 1'b0);
        exp_buf[0] = 32'd3; exp_buf[1] = 32'd3;
        chk_read("fixed_r", 2, 2'b00, 4'hA);

        // INCR wraps from the top word back to word 0
        wr_buf[0] = 32'h5A5A_0001; wr_buf[1] = 32'h5A5A_0002;
        axi_write(4'hB, 32'h3FFC, 4'd1, 2'b01, 3'b010, 4'hF, -1, -1, stalls, bwait, wresp, wbid);
        axi_read(4'hB, 32'h0, 4'd0, 2'b01, 3'b010, 1'b0);
        exp_buf[0] = 32'h5A5A_0002;
        chk_read("wrap_lo", 1, 2'b00, 4'hB);
        axi_read(4'hB, 32'h3FFC, 4'd0, 2'b01, 3'b010, 1'b0);
        exp_buf[0] = 32'h5A5A_0001;
        chk_read("wrap_hi", 1, 2'b00, 4'hB);

        // Reset in beat 5 of a 16-beat write
        for (int i = 0; i < 16; i++) wr_buf[i] = 32'hB0 + 32'(i);
        axi_write(4'hC, 32'h600, 4'd15, 2'b01, 3'b010, 4'hF, -1, 5, stalls, bwait, wresp, wbid);
        chk("abort_arready", 32'(arready), 32'd1);
        chk("abort_awready", 32'(awready), 32'd1);
        chk("abort_bvalid", 32'(bvalid), 32'd0);
        chk("abort_wready", 32'(wready), 32'd0);
        wr_buf[0] = 32'h77;
        axi_write(4'h9, 32'h700, 4'd0, 2'b01, 3'b010, 4'hF, -1, -1, stalls, bwait, wresp, wbid);
        chk("abort_next_bresp", 32'(wresp), 32'd0);
        chk("abort_next_bid", 32'(wbid), 32'h9);
        axi_read(4'hD, 32'h600, 4'd4, 2'b01, 3'b010, 1'b0);
        for (int i = 0; i < 5; i++) exp_buf[i] = 32'hB0 + 32'(i);
        chk_read("abort_r", 5, 2'b00, 4'hD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
